// File: rtl/router_fsm_if.sv
// Router FSM handshake bundle: source/FIFO status in, state strobes out.
interface router_fsm_if;
   localparam int unsigned ADDR_W = 2;

   logic              pkt_valid;
   logic [ADDR_W-1:0] data_in;
   logic              fifo_full;
   logic              fifo_empty_0;
   logic              fifo_empty_1;
   logic              fifo_empty_2;
   logic              soft_reset_0;
   logic              soft_reset_1;
   logic              soft_reset_2;
   logic              parity_done;
   logic              low_pkt_valid;

   logic              detect_add;
   logic              lfd_state;
   logic              ld_state;
   logic              laf_state;
   logic              full_state;
   logic              rst_int_reg;
   logic              write_enb_reg;
   logic              busy;

   // Driver side: source, FIFOs and register block
   modport master (
      output pkt_valid, data_in, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
      input  rst_int_reg, write_enb_reg, busy
   );

   // FSM side
   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
      output rst_int_reg, write_enb_reg, busy
   );
endinterface

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences payload/parity
// loading into the selected output FIFO and throttles the source with busy.
module router_fsm (
   input  logic          clock,
   input  logic          reset,
   router_fsm_if.slave   bus
);
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned OUT_W  = 8;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [OUT_W-1:0]  out_q, out_d;

   logic hdr_empty_c;   // empty flag of FIFO named by incoming header
   logic sel_empty_c;   // empty flag of FIFO named by latched address
   logic sel_soft_c;    // timeout flag of FIFO named by latched address

   // FIFO status muxes; address 3 selects nothing
   always_comb begin
      hdr_empty_c = 1'b0;
      sel_empty_c = 1'b0;
      sel_soft_c  = 1'b0;
      case (bus.data_in)
         2'd0:    hdr_empty_c = bus.fifo_empty_0;
         2'd1:    hdr_empty_c = bus.fifo_empty_1;
         2'd2:    hdr_empty_c = bus.fifo_empty_2;
         default: hdr_empty_c = 1'b0;
      endcase
      case (addr_q)
         2'd0: begin
            sel_empty_c = bus.fifo_empty_0;
            sel_soft_c  = bus.soft_reset_0;
         end
         2'd1: begin
            sel_empty_c = bus.fifo_empty_1;
            sel_soft_c  = bus.soft_reset_1;
         end
         2'd2: begin
            sel_empty_c = bus.fifo_empty_2;
            sel_soft_c  = bus.soft_reset_2;
         end
         default: begin
            sel_empty_c = 1'b0;
            sel_soft_c  = 1'b0;
         end
      endcase
   end

   // State, address and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= '0;
         out_q   <= OUT_W'(8'b1000_0000);
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         out_q   <= out_d;
      end
   end

   // Next-state logic; a timeout on the selected FIFO aborts the packet
   always_comb begin
      state_d = DECODE_ADDRESS;
      addr_d  = addr_q;
      case (state_q)
         DECODE_ADDRESS: begin
            state_d = DECODE_ADDRESS;
            if (bus.pkt_valid) begin
               addr_d = bus.data_in;
               if (bus.data_in != 2'd3)
                  state_d = hdr_empty_c ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
         end
         LOAD_FIRST_DATA: state_d = LOAD_DATA;
         LOAD_DATA: begin
            if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
            else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            else                     state_d = LOAD_DATA;
         end
         FIFO_FULL_STATE:
            state_d = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
         LOAD_AFTER_FULL: begin
            if (bus.parity_done)        state_d = DECODE_ADDRESS;
            else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
            else                        state_d = LOAD_DATA;
         end
         LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR:
            state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         WAIT_TILL_EMPTY:
            state_d = sel_empty_c ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         default: state_d = DECODE_ADDRESS;
      endcase
      if (state_q != DECODE_ADDRESS && sel_soft_c)
         state_d = DECODE_ADDRESS;
   end

   // Moore decode of the upcoming state, registered alongside it
   // Bit order: detect_add lfd ld laf full rst_int write_enb busy
   always_comb begin
      out_d = '0;
      case (state_d)
         DECODE_ADDRESS:     out_d = OUT_W'(8'b1000_0000);
         LOAD_FIRST_DATA:    out_d = OUT_W'(8'b0100_0001);
         LOAD_DATA:          out_d = OUT_W'(8'b0010_0010);
         LOAD_AFTER_FULL:    out_d = OUT_W'(8'b0001_0011);
         FIFO_FULL_STATE:    out_d = OUT_W'(8'b0000_1001);
         CHECK_PARITY_ERROR: out_d = OUT_W'(8'b0000_0101);
         LOAD_PARITY:        out_d = OUT_W'(8'b0000_0011);
         WAIT_TILL_EMPTY:    out_d = OUT_W'(8'b0000_0001);
         default:            out_d = OUT_W'(8'b1000_0000);
      endcase
   end

   assign bus.detect_add    = out_q[7];
   assign bus.lfd_state     = out_q[6];
   assign bus.ld_state      = out_q[5];
   assign bus.laf_state     = out_q[4];
   assign bus.full_state    = out_q[3];
   assign bus.rst_int_reg   = out_q[2];
   assign bus.write_enb_reg = out_q[1];
   assign bus.busy          = out_q[0];
endmodule
